score_display: RTL



---
 rtl/score_display.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//   Takes the 16-bit binary score from the game's score counter and shows it on
//   a 5-digit multiplexed 7-segment display.
//   On each accepted frame tick the score is snapshotted and converted to BCD by
//   a sequential double-dabble FSM (one bit per cycle). The result is latched
//   into a display register. The five digits are scanned continuously, with
//   leading-zero blanking.
//
// Parameters:
//   SCAN_DIV   clock cycles each digit stays selected (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   score      in   [15:0] binary score
//   game_tick  in   one-cycle end-of-frame pulse; starts a conversion when idle
//   seg        out  [6:0] segments, active-high, bit0 = a .. bit6 = g
//   dig_sel    out  [4:0] one-hot digit enable, bit0 = least-significant digit
//   busy       out  high while a conversion is in progress
//
// Optional feature (macro SCORE_HISCORE_EN):
//   show_hi    in   convert max(score, hi) instead of score on the accepted tick
//   new_hi     out  one-cycle pulse when an accepted tick raises the high score
// -----------------------------------------------------------------------------
module score_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic        game_tick,
`ifdef SCORE_HISCORE_EN
    input  logic        show_hi,
    output logic        new_hi,
`endif
    output logic [6:0]  seg,
    output logic [4:0]  dig_sel,
    output logic        busy
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] disp_q, disp_d;
    logic [19:0] bcd_adj;

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [2:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [4:0]        dig_sel_q, dig_sel_d;

    logic [15:0] conv_src;

`ifdef SCORE_HISCORE_EN
    logic [15:0] hi_q, hi_d;
    logic        new_hi_q, new_hi_d;

    always_comb begin
        conv_src = score;
        if (show_hi && (hi_q > score)) conv_src = hi_q;
    end
`else
    always_comb conv_src = score;
`endif

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 5; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Conversion FSM: next state and datapath.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
`ifdef SCORE_HISCORE_EN
        hi_d     = hi_q;
        new_hi_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (game_tick) begin
                    bin_d   = conv_src;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SCORE_HISCORE_EN
                    if (score > hi_q) begin
                        hi_d     = score;
                        new_hi_d = 1'b1;
                    end
`endif
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = LOAD;
            end
            LOAD: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan and registered segment/digit outputs.
    always_comb begin
        logic [3:0] digit;
        logic       blank;
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        digit = 4'd0;
        blank = 1'b0;
        case (idx_q)
            3'd0: digit = disp_q[3:0];
            3'd1: digit = disp_q[7:4];
            3'd2: digit = disp_q[11:8];
            3'd3: digit = disp_q[15:12];
            3'd4: digit = disp_q[19:16];
            default: digit = 4'd0;
        endcase
        // A digit is blank when it and every more-significant digit are zero.
        case (idx_q)
            3'd1: blank = (disp_q[19:4]  == '0);
            3'd2: blank = (disp_q[19:8]  == '0);
            3'd3: blank = (disp_q[19:12] == '0);
            3'd4: blank = (disp_q[19:16] == '0);
            default: blank = 1'b0;
        endcase

        case (digit)
            4'd0: seg_d = 7'h3F;
            4'd1: seg_d = 7'h06;
            4'd2: seg_d = 7'h5B;
            4'd3: seg_d = 7'h4F;
            4'd4: seg_d = 7'h66;
            4'd5: seg_d = 7'h6D;
            4'd6: seg_d = 7'h7D;
            4'd7: seg_d = 7'h07;
            4'd8: seg_d = 7'h7F;
            4'd9: seg_d = 7'h6F;
            default: seg_d = 7'h00;
        endcase
        if (blank) seg_d = 7'h00;
        dig_sel_d = 5'b00001 << idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h3F;
            dig_sel_q <= 5'b00001;
`ifdef SCORE_HISCORE_EN
            hi_q      <= '0;
            new_hi_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
`ifdef SCORE_HISCORE_EN
            hi_q      <= hi_d;
            new_hi_q  <= new_hi_d;
`endif
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
    assign busy    = (state_q != IDLE);
`ifdef SCORE_HISCORE_EN
    assign new_hi  = new_hi_q;
`endif

endmodule
